// File: rtl/irq_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_sequencer_if
// Description : Link between the program sequencer and the interrupt
//               sequencer.
//               Sequencer -> controller: fetch_boundary, pc_ret, reti.
//               Controller -> sequencer: irq_jmp/irq_jmp_addr (vectored jump)
//               and ret_jmp/ret_addr (return jump).
//               Modport master = program sequencer side.
//               Modport slave  = interrupt controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_sequencer_if;
    logic       fetch_boundary;
    logic [7:0] pc_ret;
    logic       reti;
    logic       irq_jmp;
    logic [7:0] irq_jmp_addr;
    logic       ret_jmp;
    logic [7:0] ret_addr;

    modport master (
        output fetch_boundary, pc_ret, reti,
        input  irq_jmp, irq_jmp_addr, ret_jmp, ret_addr
    );

    modport slave (
        input  fetch_boundary, pc_ret, reti,
        output irq_jmp, irq_jmp_addr, ret_jmp, ret_addr
    );
endinterface
`default_nettype wire

// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irq_sequencer
// Description : Prioritising, nesting interrupt controller in front of the
//               program sequencer.
//               Latches rising edges on irq, selects the highest-priority
//               enabled request (index 0 highest), and at a fetch boundary
//               issues a one-cycle vectored jump while pushing pc_ret onto a
//               return-address stack.  RETI pops the stack and issues a
//               one-cycle return jump.
// Ports       : clk, reset_n (async, active low)
//               irq          - request lines (rising-edge detected)
//               mask_wr/data - per-line enable register load
//               gie_set/clr  - global enable (clear dominates)
//               seq          - sequencer link (boundary, pc_ret, reti, jumps)
//               pending, in_service, depth, stack_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
    parameter int         NUM_IRQ     = 4,
    parameter int         STACK_DEPTH = 4,
    parameter logic [7:0] VECTOR_BASE = 8'hF0
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic [NUM_IRQ-1:0] irq,
    input  wire logic               mask_wr,
    input  wire logic [NUM_IRQ-1:0] mask_data,
    input  wire logic               gie_set,
    input  wire logic               gie_clr,
    irq_sequencer_if.slave          seq,
    output logic [NUM_IRQ-1:0]      pending,
    output logic [NUM_IRQ-1:0]      in_service,
    output logic [2:0]              depth,
    output logic                    stack_err
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_take = 2'd1;
    localparam logic [1:0] c_ret  = 2'd2;

    logic [1:0]         r_state;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_gie;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [7:0]         r_stack [STACK_DEPTH];
    logic [2:0]         r_depth;
    logic               r_stack_err;
    logic [IW-1:0]      r_cand;
    logic [7:0]         r_pc;
    logic               r_irq_jmp;
    logic [7:0]         r_irq_jmp_addr;
    logic               r_ret_jmp;
    logic [7:0]         r_ret_addr;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_take_bit;
    logic [IW-1:0]      w_cand_idx;
    logic               w_cand_any;
    logic [IW-1:0]      w_isr_idx;
    logic               w_isr_any;
    logic               w_cand_ok;
    logic [7:0]         w_top;

    assign w_edge     = irq & ~r_irq_q;
    assign w_eligible = r_pending & r_mask & {NUM_IRQ{r_gie}};
    assign w_take_bit = NUM_IRQ'(1) << r_cand;

    // Lowest set index of the eligible requests and of the active handlers;
    // scanning downward lets the lowest index overwrite the others.
    always_comb begin
        w_cand_idx = '0;
        w_cand_any = 1'b0;
        w_isr_idx  = '0;
        w_isr_any  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_cand_idx = IW'(i);
                w_cand_any = 1'b1;
            end
            if (r_in_service[i]) begin
                w_isr_idx = IW'(i);
                w_isr_any = 1'b1;
            end
        end
    end

    // Only a strictly higher priority than every active handler may preempt,
    // and only while a stack slot is free.
    assign w_cand_ok = w_cand_any
                     && (!w_isr_any || (w_cand_idx < w_isr_idx))
                     && (r_depth < 3'(STACK_DEPTH));

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (3'(i) + 3'd1 == r_depth) begin
                w_top = r_stack[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= c_idle;
            r_irq_q        <= '0;
            r_pending      <= '0;
            r_mask         <= '0;
            r_gie          <= 1'b0;
            r_in_service   <= '0;
            r_depth        <= '0;
            r_stack_err    <= 1'b0;
            r_cand         <= '0;
            r_pc           <= '0;
            r_irq_jmp      <= 1'b0;
            r_irq_jmp_addr <= '0;
            r_ret_jmp      <= 1'b0;
            r_ret_addr     <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_irq_q   <= irq;
            r_irq_jmp <= 1'b0;
            r_ret_jmp <= 1'b0;

            if (gie_clr) begin
                r_gie <= 1'b0;
            end else if (gie_set) begin
                r_gie <= 1'b1;
            end
            if (mask_wr) begin
                r_mask <= mask_data;
            end

            // A fresh edge on the bit being taken re-arms it.
            if (r_state == c_take) begin
                r_pending <= (r_pending & ~w_take_bit) | w_edge;
            end else begin
                r_pending <= r_pending | w_edge;
            end

            case (r_state)
                c_idle: begin
                    if (seq.reti) begin
                        r_state <= c_ret;
                        if (r_depth != 3'd0) begin
                            r_ret_jmp  <= 1'b1;
                            r_ret_addr <= w_top;
                        end
                    end else if (seq.fetch_boundary && w_cand_ok) begin
                        r_state        <= c_take;
                        r_cand         <= w_cand_idx;
                        r_pc           <= seq.pc_ret;
                        r_irq_jmp      <= 1'b1;
                        r_irq_jmp_addr <= VECTOR_BASE + (8'(w_cand_idx) << 2);
                    end
                end
                c_take: begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (3'(i) == r_depth) begin
                            r_stack[i] <= r_pc;
                        end
                    end
                    r_depth      <= r_depth + 3'd1;
                    r_in_service <= r_in_service | w_take_bit;
                    r_state      <= c_idle;
                end
                c_ret: begin
                    if (r_depth != 3'd0) begin
                        r_depth      <= r_depth - 3'd1;
                        // Innermost handler is always the lowest set bit.
                        r_in_service <= r_in_service & (r_in_service - NUM_IRQ'(1));
                    end else begin
                        r_stack_err <= 1'b1;
                    end
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign seq.irq_jmp      = r_irq_jmp;
    assign seq.irq_jmp_addr = r_irq_jmp_addr;
    assign seq.ret_jmp      = r_ret_jmp;
    assign seq.ret_addr     = r_ret_addr;
    assign pending          = r_pending;
    assign in_service       = r_in_service;
    assign depth            = r_depth;
    assign stack_err        = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_sequencer
// Description : Self-checking bench for irq_sequencer (4 lines, 2-deep
//               stack).  Directed scenarios followed by random traffic, all
//               compared every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

    localparam int SD = 2;

    logic       clk;
    logic       reset_n;
    logic [3:0] irq;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       gie_set;
    logic       gie_clr;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [2:0] depth;
    logic       stack_err;

    irq_sequencer_if u_if ();

    irq_sequencer #(
        .NUM_IRQ     (4),
        .STACK_DEPTH (SD),
        .VECTOR_BASE (8'hF0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq        (irq),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .gie_set    (gie_set),
        .gie_clr    (gie_clr),
        .seq        (u_if),
        .pending    (pending),
        .in_service (in_service),
        .depth      (depth),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_irq_q, m_pending, m_mask, m_isr;
    logic       m_gie, m_err;
    logic [7:0] m_stack[$];
    int         m_mode;          // 0 free, 1 jumping to handler, 2 returning
    int         m_idx;
    logic [7:0] m_pc;
    logic       m_irq_jmp, m_ret_jmp;
    logic [7:0] m_jmp_addr, m_ret_addr;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 4;
    endfunction

    task automatic model_reset();
        m_irq_q = 0; m_pending = 0; m_mask = 0; m_isr = 0;
        m_gie = 0; m_err = 0; m_stack.delete(); m_mode = 0; m_idx = 0;
        m_pc = 0; m_irq_jmp = 0; m_ret_jmp = 0; m_jmp_addr = 0; m_ret_addr = 0;
    endtask

    task automatic model_step();
        logic [3:0] edg;
        logic [3:0] np;
        int c, s;
        edg = irq & ~m_irq_q;
        c = lowest(m_pending & m_mask & {4{m_gie}});
        s = lowest(m_isr);
        np = m_pending;
        m_irq_jmp = 0;
        m_ret_jmp = 0;
        if (m_mode == 1) begin
            m_stack.push_back(m_pc);
            m_isr[m_idx] = 1'b1;
            np[m_idx] = 1'b0;
            m_mode = 0;
        end else if (m_mode == 2) begin
            if (m_stack.size() > 0) begin
                void'(m_stack.pop_back());
                if (s < 4) m_isr[s] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_mode = 0;
        end else if (u_if.reti) begin
            m_mode = 2;
            if (m_stack.size() > 0) begin
                m_ret_jmp  = 1'b1;
                m_ret_addr = m_stack[$];
            end
        end else if (u_if.fetch_boundary && c < 4 && c < s && m_stack.size() < SD) begin
            m_mode     = 1;
            m_idx      = c;
            m_pc       = u_if.pc_ret;
            m_irq_jmp  = 1'b1;
            m_jmp_addr = 8'(8'hF0 + 4 * c);
        end
        m_pending = np | edg;
        if (gie_clr) m_gie = 1'b0;
        else if (gie_set) m_gie = 1'b1;
        if (mask_wr) m_mask = mask_data;
        m_irq_q = irq;
    endtask

    task automatic compare_all();
        check("irq_jmp",      32'(u_if.irq_jmp),      32'(m_irq_jmp));
        check("irq_jmp_addr", 32'(u_if.irq_jmp_addr), 32'(m_jmp_addr));
        check("ret_jmp",      32'(u_if.ret_jmp),      32'(m_ret_jmp));
        check("ret_addr",     32'(u_if.ret_addr),     32'(m_ret_addr));
        check("pending",      32'(pending),           32'(m_pending));
        check("in_service",   32'(in_service),        32'(m_isr));
        check("depth",        32'(depth),             32'(m_stack.size()));
        check("stack_err",    32'(stack_err),         32'(m_err));
    endtask

    // One clock: apply inputs, let the edge pass, advance the model, compare.
    task automatic drive(input logic [3:0] i_irq, input logic fb, input logic [7:0] pc,
                         input logic rt, input logic mw, input logic [3:0] md,
                         input logic gs, input logic gc);
        irq = i_irq; u_if.fetch_boundary = fb; u_if.pc_ret = pc; u_if.reti = rt;
        mask_wr = mw; mask_data = md; gie_set = gs; gie_clr = gc;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic cyc(input logic [3:0] v);                  drive(v, 0, 8'h00, 0, 0, 4'h0, 0, 0); endtask
    task automatic bnd(input logic [3:0] v, input logic [7:0] pc); drive(v, 1, pc, 0, 0, 4'h0, 0, 0); endtask
    task automatic rti(input logic [3:0] v);                  drive(v, 0, 8'h00, 1, 0, 4'h0, 0, 0); endtask
    task automatic setup();                                    drive(4'h0, 0, 8'h00, 0, 1, 4'hF, 1, 0); endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        irq = 0; u_if.fetch_boundary = 0; u_if.pc_ret = 0; u_if.reti = 0;
        mask_wr = 0; mask_data = 0; gie_set = 0; gie_clr = 0;
        #1;
        check("rst_irq_jmp",    32'(u_if.irq_jmp),      32'h0);
        check("rst_jmp_addr",   32'(u_if.irq_jmp_addr), 32'h0);
        check("rst_ret_jmp",    32'(u_if.ret_jmp),      32'h0);
        check("rst_ret_addr",   32'(u_if.ret_addr),     32'h0);
        check("rst_pending",    32'(pending),           32'h0);
        check("rst_in_service", 32'(in_service),        32'h0);
        check("rst_depth",      32'(depth),             32'h0);
        check("rst_stack_err",  32'(stack_err),         32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] lv;
        reset_n = 1'b1;
        model_reset();
        do_reset();

        // Single request: take and return
        setup();
        cyc(4'b0100);
        bnd(4'b0100, 8'h23);
        check("single_jmp",  32'(u_if.irq_jmp), 32'h1);
        check("single_addr", 32'(u_if.irq_jmp_addr), 32'hF8);
        cyc(4'b0100);
        check("single_depth", 32'(depth), 32'h1);
        check("single_isr",   32'(in_service), 32'h4);
        check("single_pend",  32'(pending), 32'h0);
        rti(4'b0100);
        check("single_ret",      32'(u_if.ret_jmp), 32'h1);
        check("single_ret_addr", 32'(u_if.ret_addr), 32'h23);
        cyc(4'b0000);
        check("single_depth0", 32'(depth), 32'h0);

        // Priority and preemption
        cyc(4'b1010);
        bnd(4'b1010, 8'h30);
        check("prio_addr", 32'(u_if.irq_jmp_addr), 32'hF4);
        cyc(4'b1010);
        check("prio_pend", 32'(pending), 32'h8);
        cyc(4'b1011);
        bnd(4'b1011, 8'h40);
        check("preempt_addr", 32'(u_if.irq_jmp_addr), 32'hF0);
        cyc(4'b1011);
        check("preempt_depth", 32'(depth), 32'h2);
        rti(4'b1011);
        check("preempt_ret_addr", 32'(u_if.ret_addr), 32'h40);
        cyc(4'b1011);
        for (int k = 0; k < 3; k++) begin
            bnd(4'b1011, 8'h50);
            check("lower_no_jmp", 32'(u_if.irq_jmp), 32'h0);
        end
        rti(4'b1011);
        check("ret_addr_30", 32'(u_if.ret_addr), 32'h30);
        cyc(4'b1011);
        bnd(4'b1011, 8'h55);
        check("late_addr", 32'(u_if.irq_jmp_addr), 32'hFC);
        cyc(4'b1011);
        rti(4'b1011);
        cyc(4'b0000);

        // Masking and global enable
        do_reset();
        setup();
        drive(4'b0000, 0, 8'h00, 0, 1, 4'b1011, 0, 0);
        cyc(4'b0100);
        bnd(4'b0100, 8'h60);
        check("mask_no_jmp", 32'(u_if.irq_jmp), 32'h0);
        check("mask_pend",   32'(pending), 32'h4);
        drive(4'b0100, 0, 8'h00, 0, 0, 4'h0, 0, 1);
        drive(4'b0100, 0, 8'h00, 0, 0, 4'h0, 1, 1);
        cyc(4'b0110);
        bnd(4'b0110, 8'h61);
        check("gie_no_jmp", 32'(u_if.irq_jmp), 32'h0);
        drive(4'b0110, 0, 8'h00, 0, 0, 4'h0, 1, 0);
        bnd(4'b0110, 8'h66);
        check("gie_on_addr", 32'(u_if.irq_jmp_addr), 32'hF4);
        cyc(4'b0110);
        rti(4'b0110);
        check("gie_ret_addr", 32'(u_if.ret_addr), 32'h66);
        cyc(4'b0000);

        // Stack full
        do_reset();
        setup();
        cyc(4'b1000);
        bnd(4'b1000, 8'h11);
        cyc(4'b1000);
        cyc(4'b1100);
        bnd(4'b1100, 8'h22);
        check("nest2_addr", 32'(u_if.irq_jmp_addr), 32'hF8);
        cyc(4'b1100);
        check("full_depth", 32'(depth), 32'h2);
        cyc(4'b1101);
        bnd(4'b1101, 8'h33);
        check("full_no_jmp", 32'(u_if.irq_jmp), 32'h0);
        check("full_pend",   32'(pending), 32'h1);
        rti(4'b1101);
        check("full_ret_addr", 32'(u_if.ret_addr), 32'h22);
        cyc(4'b1101);
        bnd(4'b1101, 8'h44);
        check("full_retake", 32'(u_if.irq_jmp_addr), 32'hF0);
        cyc(4'b1101);

        // reti wins over a simultaneous take
        cyc(4'b1111);
        drive(4'b1111, 1, 8'h55, 1, 0, 4'h0, 0, 0);
        check("reti_first_ret", 32'(u_if.ret_jmp), 32'h1);
        check("reti_first_jmp", 32'(u_if.irq_jmp), 32'h0);
        check("reti_first_addr", 32'(u_if.ret_addr), 32'h44);
        cyc(4'b1111);
        bnd(4'b1111, 8'h66);
        check("after_reti_jmp",  32'(u_if.irq_jmp), 32'h1);
        check("after_reti_addr", 32'(u_if.irq_jmp_addr), 32'hF4);
        cyc(4'b1111);

        // Reset while handlers are active
        do_reset();

        // Random traffic
        setup();
        lv = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            lv = lv ^ (4'($urandom) & 4'($urandom));
            drive(lv,
                  1'($urandom_range(0, 1)),
                  8'($urandom),
                  (m_stack.size() > 0) && ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 19) == 0,
                  4'($urandom),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0);
        end

        // reti with an empty stack
        do_reset();
        rti(4'b0000);
        check("empty_ret_jmp", 32'(u_if.ret_jmp), 32'h0);
        cyc(4'b0000);
        check("empty_err", 32'(stack_err), 32'h1);
        cyc(4'b0000);
        check("err_sticky", 32'(stack_err), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
